id_ex_pipe_reg: RTL
===================

// Module: id_ex_pipe_reg
// PURPOSE
//  Parametrised ID->EX pipeline register with valid/ready handshake, flush and a 2-entry skid buffer.
//  Sits between decode and execute in the core.
//  Lets EX stall without a combinational ready path back into ID, and lets the hazard unit squash in-flight instructions.
//  Invalid slots present a NOP payload to EX.
// PARAMETERS
//  XLEN        32          data/PC/immediate width
//  RADDR_W     5           register-index width (rd)
//  SKID_EN     1           1: 2-entry skid, in_ready_o registered; 0: single entry, in_ready_o = ~main_v | out_ready_i
//  NOP_OPCODE  7'b0010011  opcode driven when slot invalid (ADDI x0,x0,0)
//  NOP_FUNCT3  3'b000      funct3 driven when invalid
//  NOP_FUNCT7  7'b0000000  funct7 driven when invalid
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous reset, active-high
//  flush_i      in   1        squash all held entries and any same-cycle input
//  in_valid_i   in   1        ID presents an instruction
//  in_ready_o   out  1        register can accept
//  rd_i         in   RADDR_W  destination register
//  imm_ext_i    in   XLEN     sign-extended immediate
//  rs1_data_i   in   XLEN     rs1 operand
//  rs2_data_i   in   XLEN     rs2 operand
//  opcode_i     in   7        opcode
//  funct3_i     in   3        funct3
//  funct7_i     in   7        funct7
//  pc_i         in   XLEN     instruction PC
//  out_valid_o  out  1        EX-side entry valid
//  out_ready_i  in   1        EX consumes entry
//  rd_o..pc_o   out  as _i    payload of head entry (main register)
//  occupancy_o  out  2        entries held (0..2; max 1 when SKID_EN=0)
// BEHAVIOUR
//  Reset (rst=1, async)
//   - state EMPTY; out_valid_o=0; occupancy_o=0; in_ready_o=1.
//   - rd_o, imm, rs1, rs2 and pc outputs = 0; opcode/funct3/funct7 = NOP_*.
//   - Reset mid-transfer discards all entries; no output glitches to valid.
//  Handshake
//   - in_fire  = in_valid_i & in_ready_o & ~flush_i
//   - out_fire = out_valid_o & out_ready_i
//   - in_valid_i may rise without waiting for in_ready_o.
//   - Payload must be stable while in_valid_i=1 and in_ready_o=0.
//  Latency and output
//   - 1 cycle from in_fire to out_valid_o when EMPTY, or when ONE with out_fire.
//   - Outputs are always the main register; no combinational input->output path.
//   - When main invalid, payload outputs = NOP values with rd=0; data fields hold 0.
//  States (SKID_EN=1); in_ready_o = (state != FULL), registered
//   - EMPTY: in_fire -> ONE (main<=in).
//   - ONE:   in_fire & out_fire  -> ONE  (main<=in).
//            in_fire & ~out_fire -> FULL (skid<=in).
//            ~in_fire & out_fire -> EMPTY.
//            else hold.
//   - FULL:  out_fire -> ONE (main<=skid; in_ready_o rises next cycle). Else hold.
//  SKID_EN=0
//   - No FULL state.
//   - in_ready_o = ~main_v | out_ready_i (combinational).
//  Flush
//   - flush_i=1 -> next state EMPTY, both entries invalid, any same-cycle input dropped.
//   - Priority: flush > out_fire/in_fire.
//   - A same-cycle out_fire still counts as consumed by EX.
//  Ordering: strict FIFO. Skid entry never overtakes main.
//  Occupancy: occupancy_o = main_v + skid_v, registered.
//  Invariant: FULL implies out_valid_o=1.
// TESTING
//  1. Reset, then in_valid with rd=5, pc=0x100 and out_ready=1.
//     -> next cycle out_valid=1, rd_o=5, pc_o=0x100, occupancy=1.
//  2. Stream of 8 back-to-back instrs with out_ready=1.
//     -> one issue/cycle, PCs 0x0..0x1C in order, in_ready stays 1.
//  3. out_ready=0 while feeding pc 0x10 then 0x14.
//     -> occupancy=2, in_ready=0; release out_ready -> 0x10 then 0x14, in_ready=1 one cycle after first pop.
//  4. FULL state, assert flush_i with in_valid=1 (pc 0x18).
//     -> next cycle out_valid=0, opcode_o=0x13, rd_o=0, occupancy=0; 0x18 never appears.
//  5. Assert rst asynchronously mid-stream (between edges).
//     -> out_valid_o=0 and opcode_o=NOP immediately; resumes cleanly after release.
//  6. SKID_EN=0 build, out_ready toggling 1/0.
//     -> in_ready follows ~main_v|out_ready same cycle, no loss/duplication over 100 random instrs.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register: valid/ready handshake, flush, optional 2-entry skid.
// The head entry lives in the main register; invalid slots present a NOP payload.
module id_ex_pipe_reg #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RADDR_W    = 5,
  parameter bit          SKID_EN    = 1'b1,
  parameter logic [6:0]  NOP_OPCODE = 7'b0010011,
  parameter logic [2:0]  NOP_FUNCT3 = 3'b000,
  parameter logic [6:0]  NOP_FUNCT7 = 7'b0000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [RADDR_W-1:0] rd_i,
  input  logic [XLEN-1:0]    imm_ext_i,
  input  logic [XLEN-1:0]    rs1_data_i,
  input  logic [XLEN-1:0]    rs2_data_i,
  input  logic [6:0]         opcode_i,
  input  logic [2:0]         funct3_i,
  input  logic [6:0]         funct7_i,
  input  logic [XLEN-1:0]    pc_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [RADDR_W-1:0] rd_o,
  output logic [XLEN-1:0]    imm_ext_o,
  output logic [XLEN-1:0]    rs1_data_o,
  output logic [XLEN-1:0]    rs2_data_o,
  output logic [6:0]         opcode_o,
  output logic [2:0]         funct3_o,
  output logic [6:0]         funct7_o,
  output logic [XLEN-1:0]    pc_o,
  output logic [1:0]         occupancy_o
);

  // Flattened payload layout: {rd, imm, rs1, rs2, opcode, funct3, funct7, pc}
  localparam int unsigned OFF_PC  = 0;
  localparam int unsigned OFF_F7  = XLEN;
  localparam int unsigned OFF_F3  = XLEN + 7;
  localparam int unsigned OFF_OP  = XLEN + 10;
  localparam int unsigned OFF_RS2 = XLEN + 17;
  localparam int unsigned OFF_RS1 = 2 * XLEN + 17;
  localparam int unsigned OFF_IMM = 3 * XLEN + 17;
  localparam int unsigned OFF_RD  = 4 * XLEN + 17;
  localparam int unsigned PL_W    = 4 * XLEN + 17 + RADDR_W;

  localparam logic [PL_W-1:0] NOP_PL = {RADDR_W'(0), XLEN'(0), XLEN'(0), XLEN'(0),
                                        NOP_OPCODE, NOP_FUNCT3, NOP_FUNCT7, XLEN'(0)};

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PL_W-1:0] r_main;
  logic [PL_W-1:0] r_skid;
  logic            r_main_v;
  logic [1:0]      r_occ;
  logic [PL_W-1:0] w_in_pl;
  logic            w_in_ready;
  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_load_main_in;
  logic            w_load_main_skid;
  logic            w_load_skid;
  logic            w_clear_main;

  assign w_in_pl    = {rd_i, imm_ext_i, rs1_data_i, rs2_data_i, opcode_i, funct3_i, funct7_i, pc_i};
  assign w_in_fire  = in_valid_i & w_in_ready & ~flush_i;
  assign w_out_fire = r_main_v & out_ready_i;

  // Ready is a flop with the skid (no comb path from EX); otherwise it looks through to EX.
  generate
    if (SKID_EN) begin : g_skid_ready
      logic r_in_ready;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_in_ready <= 1'b1;
        else     r_in_ready <= (w_state_nxt != ST_FULL);
      end
      assign w_in_ready = r_in_ready;
    end else begin : g_comb_ready
      assign w_in_ready = ~r_main_v | out_ready_i;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    w_clear_main     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt    = ST_ONE;
          w_load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_load_main_in = 1'b1;
        end else if (w_in_fire) begin
          w_state_nxt = ST_FULL;
          w_load_skid = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt  = ST_EMPTY;
          w_clear_main = 1'b1;
        end
      end
      ST_FULL: begin
        if (w_out_fire) begin
          w_state_nxt      = ST_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt  = ST_EMPTY;
        w_clear_main = 1'b1;
      end
    endcase
    // Flush wins over any transfer; a same-cycle pop has still been taken by EX.
    if (flush_i) begin
      w_state_nxt      = ST_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      w_clear_main     = 1'b1;
    end
  end

  // Main register reloads NOP whenever it goes empty, so outputs come straight off flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_main <= NOP_PL;
    else if (w_clear_main)     r_main <= NOP_PL;
    else if (w_load_main_in)   r_main <= w_in_pl;
    else if (w_load_main_skid) r_main <= r_skid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_skid <= NOP_PL;
    else if (flush_i)     r_skid <= NOP_PL;
    else if (w_load_skid) r_skid <= w_in_pl;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_v <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      r_main_v <= (w_state_nxt != ST_EMPTY);
      case (w_state_nxt)
        ST_ONE:  r_occ <= 2'd1;
        ST_FULL: r_occ <= 2'd2;
        default: r_occ <= 2'd0;
      endcase
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = r_main_v;
  assign occupancy_o = r_occ;
  assign rd_o        = r_main[OFF_RD  +: RADDR_W];
  assign imm_ext_o   = r_main[OFF_IMM +: XLEN];
  assign rs1_data_o  = r_main[OFF_RS1 +: XLEN];
  assign rs2_data_o  = r_main[OFF_RS2 +: XLEN];
  assign opcode_o    = r_main[OFF_OP  +: 7];
  assign funct3_o    = r_main[OFF_F3  +: 3];
  assign funct7_o    = r_main[OFF_F7  +: 7];
  assign pc_o        = r_main[OFF_PC  +: XLEN];

endmodule
